// File: rtl/bn_pkg.sv
// Shared widths, saturation limits and mode levels for the layer7 batch-norm/residual stage.
// Combinational helper only; no state, no flow control.
package bn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PROD_WIDTH = 32;
    localparam int ACC_WIDTH  = 34;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_CALC = 1'b1;

    function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
        if (v > ACC_WIDTH'(SAT_MAX)) begin
            return DATA_WIDTH'(SAT_MAX);
        end
        if (v < ACC_WIDTH'(SAT_MIN)) begin
            return DATA_WIDTH'(SAT_MIN);
        end
        return DATA_WIDTH'(v);
    endfunction

endpackage

// File: rtl/bn_res_layer7_if.sv
// Bundle of residual/conv vectors, parameter load port and result vector for bn_res_layer7.
// master = upstream driver, slave = the bn_res_layer7 stage.
interface bn_res_layer7_if
    import bn_pkg::*;
#(
    parameter int FM_DEPTH = 256
);
    logic                          mode;
    logic                          vs;
    logic signed [DATA_WIDTH-1:0]  res_in  [FM_DEPTH];
    logic                          res_e;
    logic signed [DATA_WIDTH-1:0]  conv_in [FM_DEPTH];
    logic                          conv_e;
    logic                          param_we;
    logic [$clog2(FM_DEPTH)-1:0]   param_addr;
    logic signed [DATA_WIDTH-1:0]  param_k;
    logic signed [DATA_WIDTH-1:0]  param_b;
    logic signed [DATA_WIDTH-1:0]  data_out [FM_DEPTH];
    logic                          data_e_out;
    logic                          vs_next;
    logic [1:0]                    err;

    modport master (
        output mode, vs, res_in, res_e, conv_in, conv_e,
               param_we, param_addr, param_k, param_b,
        input  data_out, data_e_out, vs_next, err
    );

    modport slave (
        input  mode, vs, res_in, res_e, conv_in, conv_e,
               param_we, param_addr, param_k, param_b,
        output data_out, data_e_out, vs_next, err
    );

endinterface

// File: rtl/res_fifo.sv
// Vector FIFO of residuals; head readable combinationally, push/pop take effect at the clock edge.
// No backpressure: a push when full is dropped (overflow pulse), a pop when empty flags underflow.
module res_fifo
    import bn_pkg::*;
#(
    parameter int FM_DEPTH   = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic signed [DATA_WIDTH-1:0] din  [FM_DEPTH],
    output logic signed [DATA_WIDTH-1:0] dout [FM_DEPTH],
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH][FM_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A pop frees the slot this same cycle, so a push at full still lands.
    assign do_push   = push && (!full || do_pop);
    assign overflow  = push && !do_push;
    assign underflow = pop && empty;

    always_comb begin
        for (int i = 0; i < FM_DEPTH; i++) begin
            dout[i] = mem[rd_ptr][i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                mem[wr_ptr][i] <= din[i];
            end
        end
    end

endmodule

// File: rtl/bn_res_layer7.sv
// Per-channel batch-norm (k*x+b) plus buffered residual, rounded and saturated to 16 bits.
// Latency 3 cycles conv_e -> data_e_out, one result per cycle; no backpressure, FIFO errors are sticky in err.
module bn_res_layer7
    import bn_pkg::*;
#(
    parameter int FM_DEPTH   = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAC_BITS  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    bn_res_layer7_if.slave io
);
    localparam logic signed [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);

    logic signed [DATA_WIDTH-1:0] k_mem    [FM_DEPTH];
    logic signed [DATA_WIDTH-1:0] b_mem    [FM_DEPTH];
    logic signed [DATA_WIDTH-1:0] res_head [FM_DEPTH];
    logic signed [DATA_WIDTH-1:0] r_sel    [FM_DEPTH];
    logic signed [PROD_WIDTH-1:0] prod     [FM_DEPTH];
    logic signed [ACC_WIDTH-1:0]  sum      [FM_DEPTH];
    logic signed [DATA_WIDTH-1:0] sat      [FM_DEPTH];
    logic signed [PROD_WIDTH-1:0] p1       [FM_DEPTH];
    logic signed [DATA_WIDTH-1:0] r1       [FM_DEPTH];
    logic signed [ACC_WIDTH-1:0]  s2       [FM_DEPTH];

    logic       v1;
    logic       v2;
    logic [1:0] vs_pipe;
    logic       calc;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       ovf;
    logic       unf;

    assign calc = (io.mode == MODE_CALC) && !io.vs;
    assign push = calc && io.res_e;
    assign pop  = calc && io.conv_e;

    res_fifo #(
        .FM_DEPTH   (FM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (io.vs),
        .push      (push),
        .pop       (pop),
        .din       (io.res_in),
        .dout      (res_head),
        .empty     (fifo_empty),
        .overflow  (ovf),
        .underflow (unf)
    );

    for (genvar i = 0; i < FM_DEPTH; i++) begin : g_ch
        assign r_sel[i] = fifo_empty ? '0 : res_head[i];
        assign prod[i]  = PROD_WIDTH'(io.conv_in[i]) * PROD_WIDTH'(k_mem[i]);
        // b is already Q.FRAC like the product; only the integer residual needs aligning.
        assign sum[i]   = ACC_WIDTH'(p1[i]) + ACC_WIDTH'(b_mem[i])
                        + (ACC_WIDTH'(r1[i]) <<< FRAC_BITS);
        assign sat[i]   = sat16((s2[i] + ROUND) >>> FRAC_BITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                k_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if ((io.mode == MODE_LOAD) && io.param_we) begin
            k_mem[io.param_addr] <= io.param_k;
            b_mem[io.param_addr] <= io.param_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            io.data_e_out <= 1'b0;
            vs_pipe       <= '0;
            io.vs_next    <= 1'b0;
            io.err        <= '0;
            for (int i = 0; i < FM_DEPTH; i++) begin
                p1[i]          <= '0;
                r1[i]          <= '0;
                s2[i]          <= '0;
                io.data_out[i] <= '0;
            end
        end else begin
            v1            <= pop;
            v2            <= v1 && !io.vs;
            io.data_e_out <= v2 && !io.vs;
            vs_pipe       <= {vs_pipe[0], io.vs};
            io.vs_next    <= vs_pipe[1];
            io.err        <= io.err | {unf, ovf};
            for (int i = 0; i < FM_DEPTH; i++) begin
                if (pop) begin
                    p1[i] <= prod[i];
                    r1[i] <= r_sel[i];
                end
                if (v1) s2[i] <= sum[i];
                // A frame sync on the output cycle discards the result, so data_out holds.
                if (v2 && !io.vs) io.data_out[i] <= sat[i];
            end
        end
    end

endmodule
